// File: rtl/sdram_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters into one SDRAM controller port.
// Read returns are routed back to their requester through an in-order tag FIFO.
module sdram_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TAGDEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ*24-1:0]   r_addr,
    input  logic [NREQ*16-1:0]   r_data,
    input  logic [NREQ-1:0]      r_we,
    input  logic [NREQ-1:0]      r_req,
    output logic [NREQ-1:0]      r_rdy,
    output logic [15:0]          r_rdata,
    output logic [NREQ-1:0]      r_rvalid,
    output logic [23:0]          m_addr,
    output logic [15:0]          m_data,
    output logic                 m_we,
    output logic                 m_req,
    input  logic                 m_rdy,
    input  logic [23:0]          m_raddr,
    input  logic [15:0]          m_rdata,
    input  logic                 m_rvalid,
    output logic                 tag_err
);

    localparam int unsigned TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = $clog2(TAGDEPTH);
    localparam int unsigned CW = PW + 1;

    logic [TW-1:0]   ptr_q;
    logic [TW-1:0]   sel;
    logic [TW-1:0]   idx;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] gnt;
    logic            done;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [TW-1:0]   tag_mem [TAGDEPTH];
    logic [TW-1:0]   head;
    logic            full, empty, xfer, push, pop;

    logic [NREQ-1:0] r_rvalid_q;
    logic [15:0]     r_rdata_q;
    logic            tag_err_q;

    // Return address is not needed: returns arrive in issue order.
    logic            unused_raddr;
    assign unused_raddr = ^m_raddr;

    assign full  = (count_q == CW'(TAGDEPTH));
    assign empty = (count_q == '0);
    assign head  = tag_mem[rd_ptr_q];

    // Reads need a free tag slot; writes never consume one.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            elig[i] = r_req[i] & (r_we[i] | ~full);
        end
    end

    always_comb begin
        gnt  = '0;
        sel  = ptr_q;
        idx  = '0;
        done = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = TW'((32'(ptr_q) + k) % NREQ);
            if (!done && elig[idx]) begin
                sel      = idx;
                gnt[idx] = 1'b1;
                done     = 1'b1;
            end
        end
    end

    always_comb begin
        m_addr = '0;
        m_data = '0;
        m_we   = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                m_addr = r_addr[i*24 +: 24];
                m_data = r_data[i*16 +: 16];
                m_we   = r_we[i];
            end
        end
    end

    assign m_req = |elig;
    assign xfer  = m_req & m_rdy;
    assign r_rdy = xfer ? gnt : '0;
    assign push  = xfer & ~m_we;
    // A return with no outstanding tag is an error, even if a tag is pushed this cycle.
    assign pop   = m_rvalid & ~empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= TW'(NREQ - 1);
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            r_rvalid_q <= '0;
            r_rdata_q  <= '0;
            tag_err_q  <= 1'b0;
        end else begin
            if (xfer) begin
                ptr_q <= sel;
            end
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            r_rvalid_q <= '0;
            if (pop) begin
                r_rvalid_q[head] <= 1'b1;
                r_rdata_q        <= m_rdata;
            end
            if (m_rvalid && empty) begin
                tag_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= sel;
        end
    end

    assign r_rvalid = r_rvalid_q;
    assign r_rdata  = r_rdata_q;
    assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter (NREQ=4, TAGDEPTH=8).
module tb_sdram_arbiter;

    logic         clk;
    logic         reset;
    logic [95:0]  r_addr;
    logic [63:0]  r_data;
    logic [3:0]   r_we;
    logic [3:0]   r_req;
    logic [3:0]   r_rdy;
    logic [15:0]  r_rdata;
    logic [3:0]   r_rvalid;
    logic [23:0]  m_addr;
    logic [15:0]  m_data;
    logic         m_we;
    logic         m_req;
    logic         m_rdy;
    logic [23:0]  m_raddr;
    logic [15:0]  m_rdata;
    logic         m_rvalid;
    logic         tag_err;

    int total = 0;
    int bad   = 0;

    sdram_arbiter #(
        .NREQ     (4),
        .TAGDEPTH (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .r_we     (r_we),
        .r_req    (r_req),
        .r_rdy    (r_rdy),
        .r_rdata  (r_rdata),
        .r_rvalid (r_rvalid),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_we     (m_we),
        .m_req    (m_req),
        .m_rdy    (m_rdy),
        .m_raddr  (m_raddr),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .tag_err  (tag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [23:0] addr_of(input int i);
        return 24'h0A0000 + 24'(i);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 4; i++) begin
            r_addr[i*24 +: 24] = addr_of(i);
            r_data[i*16 +: 16] = 16'h5000 + 16'(i);
        end
        r_we     = '0;
        r_req    = '0;
        m_rdy    = 1'b0;
        m_raddr  = 24'h3C3C3C;
        m_rdata  = '0;
        m_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        total++; if (r_rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid got=%b exp=0000", r_rvalid); end
        total++; if (r_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", r_rdata); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL reset_tag_err got=%b exp=0", tag_err); end
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req_idle got=%b exp=0", m_req); end
        r_req = 4'b1111;
        m_rdy = 1'b1;
        #1;
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL reset_m_req_busy got=%b exp=1", m_req); end
        total++; if (r_rdy !== 4'b0001) begin bad++; $display("FAIL reset_r_rdy got=%b exp=0001", r_rdy); end
        total++; if (m_addr !== addr_of(0)) begin bad++; $display("FAIL reset_m_addr got=%h exp=%h", m_addr, addr_of(0)); end
        step();
        // ptr must still be 3 after a handshake seen during reset
        total++; if (r_rdy !== 4'b0001) begin bad++; $display("FAIL reset_hold_ptr got=%b exp=0001", r_rdy); end
        clear_inputs();
        reset = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int         exp_i [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_i = '{0, 1, 2, 3, 0};
        do_reset();
        r_req = 4'b1111;
        m_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (r_rdy !== exp_g[k]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, r_rdy, exp_g[k]); end
            total++; if (m_addr !== addr_of(exp_i[k])) begin bad++; $display("FAIL rr_addr%0d got=%h exp=%h", k, m_addr, addr_of(exp_i[k])); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_read_return();
        do_reset();
        r_addr[1*24 +: 24] = 24'h000123;
        r_addr[3*24 +: 24] = 24'h000456;
        r_req = 4'b1010;
        m_rdy = 1'b1;
        #1;
        total++; if (r_rdy !== 4'b0010) begin bad++; $display("FAIL rd_grant1 got=%b exp=0010", r_rdy); end
        total++; if (m_addr !== 24'h000123) begin bad++; $display("FAIL rd_addr1 got=%h exp=000123", m_addr); end
        step();
        total++; if (r_rdy !== 4'b1000) begin bad++; $display("FAIL rd_grant3 got=%b exp=1000", r_rdy); end
        total++; if (m_addr !== 24'h000456) begin bad++; $display("FAIL rd_addr3 got=%h exp=000456", m_addr); end
        step();
        r_req    = 4'b0000;
        m_rvalid = 1'b1;
        m_rdata  = 16'hAAAA;
        m_raddr  = 24'h000456;
        #1;
        total++; if (r_rvalid !== 4'b0000) begin bad++; $display("FAIL rd_early got=%b exp=0000", r_rvalid); end
        step();
        m_rdata = 16'hBBBB;
        m_raddr = 24'h000123;
        total++; if (r_rvalid !== 4'b0010) begin bad++; $display("FAIL rd_rvalid1 got=%b exp=0010", r_rvalid); end
        total++; if (r_rdata !== 16'hAAAA) begin bad++; $display("FAIL rd_rdata1 got=%h exp=AAAA", r_rdata); end
        step();
        m_rvalid = 1'b0;
        total++; if (r_rvalid !== 4'b1000) begin bad++; $display("FAIL rd_rvalid3 got=%b exp=1000", r_rvalid); end
        total++; if (r_rdata !== 16'hBBBB) begin bad++; $display("FAIL rd_rdata3 got=%h exp=BBBB", r_rdata); end
        step();
        total++; if (r_rvalid !== 4'b0000) begin bad++; $display("FAIL rd_idle got=%b exp=0000", r_rvalid); end
        total++; if (r_rdata !== 16'hBBBB) begin bad++; $display("FAIL rd_hold got=%h exp=BBBB", r_rdata); end
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL rd_tag_err got=%b exp=0", tag_err); end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        r_req = 4'b0100;
        m_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (m_req !== 1'b1 || r_rdy !== 4'b0000 || m_addr !== addr_of(2)) begin
                bad++; $display("FAIL stall%0d got m_req=%b r_rdy=%b m_addr=%h exp 1 0000 %h", k, m_req, r_rdy, m_addr, addr_of(2));
            end
            step();
        end
        m_rdy = 1'b1;
        #1;
        total++; if (r_rdy !== 4'b0100) begin bad++; $display("FAIL stall_grant got=%b exp=0100", r_rdy); end
        step();
        r_req = 4'b1111;
        #1;
        total++; if (r_rdy !== 4'b1000) begin bad++; $display("FAIL stall_next got=%b exp=1000", r_rdy); end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        r_req = 4'b0001;
        m_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (r_rdy !== 4'b0001) begin bad++; $display("FAIL full_fill%0d got=%b exp=0001", k, r_rdy); end
            step();
        end
        total++; if (m_req !== 1'b0 || r_rdy !== 4'b0000) begin bad++; $display("FAIL full_hold got m_req=%b r_rdy=%b exp 0 0000", m_req, r_rdy); end
        r_we = 4'b0001;
        #1;
        total++; if (m_req !== 1'b1 || m_we !== 1'b1 || r_rdy !== 4'b0001) begin
            bad++; $display("FAIL full_write got m_req=%b m_we=%b r_rdy=%b exp 1 1 0001", m_req, m_we, r_rdy);
        end
        total++; if (m_data !== 16'h5000) begin bad++; $display("FAIL full_wdata got=%h exp=5000", m_data); end
        step();
        r_we     = 4'b0000;
        m_rvalid = 1'b1;
        m_rdata  = 16'h1234;
        #1;
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL full_pop_cycle got=%b exp=0", m_req); end
        step();
        m_rvalid = 1'b0;
        total++; if (r_rvalid !== 4'b0001 || r_rdata !== 16'h1234) begin
            bad++; $display("FAIL full_return got rvalid=%b rdata=%h exp 0001 1234", r_rvalid, r_rdata);
        end
        total++; if (r_rdy !== 4'b0001) begin bad++; $display("FAIL full_regrant got=%b exp=0001", r_rdy); end
        step();
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL full_again got=%b exp=0", m_req); end
        clear_inputs();
    endtask

    task automatic test_tag_err();
        do_reset();
        m_rvalid = 1'b1;
        m_rdata  = 16'hDEAD;
        step();
        m_rvalid = 1'b0;
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL terr_set got=%b exp=1", tag_err); end
        total++; if (r_rvalid !== 4'b0000 || r_rdata !== 16'h0000) begin
            bad++; $display("FAIL terr_no_return got rvalid=%b rdata=%h exp 0000 0000", r_rvalid, r_rdata);
        end
        step();
        step();
        total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL terr_sticky got=%b exp=1", tag_err); end
        do_reset();
        total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL terr_clear got=%b exp=0", tag_err); end
        // Return in the same cycle as the first push into an empty FIFO
        r_req    = 4'b0010;
        m_rdy    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 16'hBEEF;
        step();
        r_req = 4'b0000;
        total++; if (tag_err !== 1'b1 || r_rvalid !== 4'b0000) begin
            bad++; $display("FAIL terr_same_cycle got tag_err=%b rvalid=%b exp 1 0000", tag_err, r_rvalid);
        end
        m_rdata = 16'hCAFE;
        step();
        m_rvalid = 1'b0;
        total++; if (r_rvalid !== 4'b0010 || r_rdata !== 16'hCAFE) begin
            bad++; $display("FAIL terr_kept_tag got rvalid=%b rdata=%h exp 0010 CAFE", r_rvalid, r_rdata);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        r_req = 4'b0111;
        m_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (r_rdy !== (4'b0001 << k)) begin bad++; $display("FAIL mid_grant%0d got=%b exp=%b", k, r_rdy, 4'b0001 << k); end
            step();
        end
        do_reset();
        m_rvalid = 1'b1;
        m_rdata  = 16'h7777;
        step();
        m_rvalid = 1'b0;
        total++; if (tag_err !== 1'b1 || r_rvalid !== 4'b0000) begin
            bad++; $display("FAIL mid_discard got tag_err=%b rvalid=%b exp 1 0000", tag_err, r_rvalid);
        end
        r_req = 4'b1111;
        m_rdy = 1'b1;
        #1;
        total++; if (r_rdy !== 4'b0001) begin bad++; $display("FAIL mid_priority got=%b exp=0001", r_rdy); end
        step();
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_read_return();
        test_stall();
        test_full();
        test_tag_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requester ports, range 2..8.
REQ-002 Parameter TAGDEPTH, default 8: read-tag FIFO depth, a power of two from 4 to 16.
REQ-003 clk  in  1  Single clock shared with the SDRAM controller; all state SHALL update on posedge clk.
REQ-004 reset  in  1  Synchronous, active-high reset.
REQ-005 r_addr  in  NREQx24  Per-requester word address.
REQ-006 r_data  in  NREQx16  Per-requester write data.
REQ-007 r_we  in  NREQ  Per-requester write flag.
REQ-008 r_req  in  NREQ  Per-requester request valid.
REQ-009 r_rdy  out  NREQ  Per-requester accept strobe; a transfer occurs when r_req[i]&r_rdy[i] at posedge.
REQ-010 r_rdata  out  16  Read data, common to all requesters.
REQ-011 r_rvalid  out  NREQ  One-hot read-data valid per requester.
REQ-012 m_addr/m_data/m_we/m_req  out  24/16/1/1  Request to the SDRAM controller.
REQ-013 m_rdy  in  1  Controller accept; a request is taken when m_req&m_rdy at posedge.
REQ-014 m_raddr/m_rdata/m_rvalid  in  24/16/1  Controller read return, delivered in issue order.
REQ-015 tag_err  out  1  Sticky flag for a read return received with the tag FIFO empty.

Function
REQ-016 Round-robin arbitration: search starts at index ptr+1 (mod NREQ) and selects the first eligible requester.
REQ-017 Eligible: r_req[i]=1 and (r_we[i]=1 or tag FIFO count<TAGDEPTH).
REQ-018 m_req=1 iff any requester is eligible; m_addr/m_data/m_we SHALL be driven combinationally from the selected requester.
REQ-019 r_rdy[sel]=m_rdy&m_req; all other r_rdy bits SHALL be 0, and r_rdy SHALL be one-hot or zero.
REQ-020 ptr updates to sel only on the m_req&m_rdy handshake; otherwise ptr holds, so selection stays stable while m_rdy=0 unless r_req changes.
REQ-021 On an accepted read (m_we=0), sel SHALL be pushed into the tag FIFO the same cycle.
REQ-022 A write SHALL push no tag.
REQ-023 On m_rvalid=1 with the FIFO non-empty, the head tag t SHALL be popped.
REQ-024 One cycle after such an m_rvalid, r_rdata=m_rdata and r_rvalid=1<<t (registered); otherwise r_rvalid=0 and r_rdata holds.
REQ-025 Read latency through the block: one clk from m_rvalid to r_rvalid; request path is zero-latency (combinational).
REQ-026 Simultaneous push and pop SHALL keep count unchanged.
REQ-027 No push SHALL occur at count=TAGDEPTH even if a pop happens the same cycle (reads ineligible per REQ-017).
REQ-028 m_rvalid with count=0 (including a same-cycle push into an empty FIFO) SHALL set tag_err, pop nothing, and assert no r_rvalid.
REQ-029 FIFO pointers SHALL be log2(TAGDEPTH) bits and wrap modulo TAGDEPTH.
REQ-030 Count SHALL be log2(TAGDEPTH)+1 bits.
REQ-031 m_raddr is unused for routing and SHALL NOT affect behaviour.

Reset
REQ-032 While reset=1, at posedge the block SHALL set ptr=NREQ-1, FIFO count/pointers=0, r_rvalid=0, r_rdata=0, tag_err=0.
REQ-033 After reset, requester 0 has first priority.
REQ-034 Reset asserted mid-operation SHALL discard outstanding tags; returns arriving afterwards set tag_err.
REQ-035 Combinational outputs follow REQ-018/019 during reset, using the reset register values.

Verification
REQ-036 Scenario: all four r_req=1 and all reads, m_rdy=1 continuously -> grant order 0,1,2,3,0; each r_rdy pulse is one cycle wide.
REQ-037 Scenario: req1 read at 0x000123, req3 read at 0x000456, returns 0xAAAA then 0xBBBB -> r_rvalid=0010 with 0xAAAA, then 1000 with 0xBBBB, each one cycle after the matching m_rvalid.
REQ-038 Scenario: m_rdy=0 for 5 cycles with req2 pending -> m_req=1, m_addr stable, r_rdy=0; req2 is granted in the first cycle m_rdy=1.
REQ-039 Scenario: issue 8 reads with no returns -> count=8; further reads are held; a write from req0 is still granted; one return drops count to 7 and a read is granted the next cycle.
REQ-040 Scenario: m_rvalid=1 with FIFO empty -> tag_err=1 and it stays 1; r_rvalid stays 0; reset clears tag_err.
REQ-041 Scenario: reset pulsed with 3 reads outstanding -> count=0 and ptr=3; the next request from req0 is granted first.
